// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional madd/maddu/msub/msubu (ops 7-10) are built only when MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [63:0]   pend, pend_next;
  logic          pend_wr, pend_wr_next;
  logic [31:0]   hi_next, lo_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, abs_bg, div_bg;
  logic [31:0] uq_s, ur_s, sq, sr, uq, ur;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    abs_a  = A[31] ? (~A + 32'd1) : A;
    abs_b  = B[31] ? (~B + 32'd1) : B;
    abs_bg = (abs_b == 32'd0) ? 32'd1 : abs_b;
    div_bg = (B == 32'd0) ? 32'd1 : B;
    uq_s   = abs_a / abs_bg;
    ur_s   = abs_a % abs_bg;
    sq     = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
    sr     = A[31] ? (~ur_s + 32'd1) : ur_s;
    uq     = A / div_bg;
    ur     = A % div_bg;
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_next    = pend;
    pend_wr_next = pend_wr;
    hi_next      = hi;
    lo_next      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            4'd1: begin
              pend_next    = prod_s;
              pend_wr_next = 1'b1;
              cnt_next     = CW'(MULT_CYCLES);
              state_next   = BUSY;
            end
            4'd2: begin
              pend_next    = prod_u;
              pend_wr_next = 1'b1;
              cnt_next     = CW'(MULT_CYCLES);
              state_next   = BUSY;
            end
            4'd3: begin
              pend_next    = {sr, sq};
              pend_wr_next = (B != 32'd0);
              cnt_next     = CW'(DIV_CYCLES);
              state_next   = BUSY;
            end
            4'd4: begin
              pend_next    = {ur, uq};
              pend_wr_next = (B != 32'd0);
              cnt_next     = CW'(DIV_CYCLES);
              state_next   = BUSY;
            end
            4'd5: hi_next = A;
            4'd6: lo_next = A;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
              case (mdu_op)
                4'd7:    pend_next = {hi, lo} + prod_s;
                4'd8:    pend_next = {hi, lo} + prod_u;
                4'd9:    pend_next = {hi, lo} - prod_s;
                default: pend_next = {hi, lo} - prod_u;
              endcase
              pend_wr_next = 1'b1;
              cnt_next     = CW'(MULT_CYCLES);
              state_next   = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_next = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (pend_wr) {hi_next, lo_next} = pend;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend    <= pend_next;
      pend_wr <= pend_wr_next;
      hi      <= hi_next;
      lo      <= lo_next;
    end
  end

  assign busy = (state == BUSY);
endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - randomized bench for e_mdu against a behavioural HI/LO model
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  e_mdu dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic last_busy = 1'b0;

  // Model: architectural HI/LO, cycles left in the current op, and the result it will deliver.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int          m_left = 0;
  bit          m_commit = 1'b0;
  logic [63:0] m_res = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_left = 0; m_commit = 0; m_res = 0;
  endtask

  task automatic model_step(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {m_hi, m_lo};
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) {m_hi, m_lo} = m_res;
    end else if (st) begin
      case (op)
        4'd1: begin m_res = sa * sb; m_commit = 1; m_left = 5; end
        4'd2: begin m_res = ua * ub; m_commit = 1; m_left = 5; end
        4'd3: begin
          m_commit = (b != 0); m_left = 10;
          if (b != 0) begin
            longint q, r;
            q = sa / sb;
            r = sa % sb;
            m_res = {r[31:0], q[31:0]};
          end
        end
        4'd4: begin
          m_commit = (b != 0); m_left = 10;
          if (b != 0) m_res = {a % b, a / b};
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
`ifdef MDU_MADD_EN
        4'd7:  begin m_res = acc + sa * sb; m_commit = 1; m_left = 5; end
        4'd8:  begin m_res = acc + ua * ub; m_commit = 1; m_left = 5; end
        4'd9:  begin m_res = acc - sa * sb; m_commit = 1; m_left = 5; end
        4'd10: begin m_res = acc - ua * ub; m_commit = 1; m_left = 5; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    last_busy = busy;
    start = st; mdu_op = op; A = a; B = b;
    @(posedge clk);
    if (!reset) model_step(st, op, a, b);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    cycle(1'b1, op, a, b);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 4'd0, 32'd0, 32'd0);
      if (last_busy) n++;
      else break;
    end
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("cyc_busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
      check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_busy_len", n, 5);
    check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

    run_op(4'd4, 32'd100, 32'd7, n);
    check("divu_busy_len", n, 10);
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, hi}, 64'd0);

    cycle(1'b1, 4'd5, 32'h1234_5678, 32'd0);
    #1;
    check("mthi_busy", {63'd0, busy}, 64'd0);
    check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    cycle(1'b1, 4'd6, 32'h9ABC_DEF0, 32'd0);
    #1;
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
    run_op(4'd3, 32'd55, 32'd0, n);
    check("div0_busy_len", n, 10);
    check("div0_hi", {32'd0, hi}, 64'h1234_5678);
    check("div0_lo", {32'd0, lo}, 64'h9ABC_DEF0);

    // Reset landing inside a busy period must drop the pending result.
    cycle(1'b1, 4'd1, 32'd3, 32'd4);
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    model_reset();
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(posedge clk);
    #1;
    check("abort_hold_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd1, 32'd3, 32'd4, n);
    check("post_rst_busy_len", n, 5);
    check("post_rst_lo", {32'd0, lo}, 64'd12);

    cycle(1'b1, 4'd1, 32'd7, 32'd6);
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
    cycle(1'b1, 4'd1, 32'd100, 32'd100);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("ignored_hi", {32'd0, hi}, 64'd0);
    check("ignored_lo", {32'd0, lo}, 64'd42);

    cycle(1'b1, 4'd5, 32'd0, 32'd0);
    cycle(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0);
    run_op(4'd8, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    check("maddu_busy_len", n, 5);
    check("maddu_hi", {32'd0, hi}, 64'd1);
    check("maddu_lo", {32'd0, lo}, 64'd0);
`else
    check("maddu_busy_len", n, 0);
    check("maddu_hi", {32'd0, hi}, 64'd0);
    check("maddu_lo", {32'd0, lo}, 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), pick(), pick());
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
